// File: rtl/lock_restart_ctrl.sv
// Lock-loss / software restart controller for the power-on-reset sequencer.
// Optional restart counter output is built when RESTART_CNT_EN is defined.
module lock_restart_ctrl #(
  parameter int unsigned DBNC_LEN = 16,
  parameter int unsigned PLS_LEN  = 4,
  parameter int unsigned HOLDOFF  = 20'hFFFFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       QPLL_LOCK,
  input  logic       MMCM_LOCK,
  input  logic       SW_RESTART,
  output logic       RESTART_ALL,
  output logic [1:0] FAULT_SRC,
  output logic [2:0] RCTL_STATE
`ifdef RESTART_CNT_EN
  ,
  output logic [7:0] RESTART_CNT
`endif
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StMonitor  = 3'd1;
  localparam logic [2:0] StDebounce = 3'd2;
  localparam logic [2:0] StRestart  = 3'd3;
  localparam logic [2:0] StW4Drop   = 3'd4;
  localparam logic [2:0] StW4Run    = 3'd5;
  localparam logic [2:0] StHoldoff  = 3'd6;

  localparam logic [7:0]  DbncLast = 8'(DBNC_LEN - 1);
  localparam logic [3:0]  PlsLen   = 4'(PLS_LEN);
  localparam logic [20:0] HoldLim  = 21'(HOLDOFF);

  logic [2:0]  state_q, state_d;
  logic [7:0]  dbnc_q, dbnc_d;
  logic [3:0]  pls_q, pls_d;
  logic [19:0] hold_q, hold_d;
  logic [1:0]  fault_q, fault_d;
  logic        pulse_q, pulse_d;
  logic        sw_q;
  logic        lock_lost;
  logic        sw_rise;

  assign lock_lost = ~QPLL_LOCK | ~MMCM_LOCK;
  assign sw_rise   = SW_RESTART & ~sw_q;

  always_comb begin
    state_d = state_q;
    dbnc_d  = dbnc_q;
    pls_d   = pls_q;
    hold_d  = hold_q;
    fault_d = fault_q;
    pulse_d = 1'b0;
    case (state_q)
      StIdle: begin
        dbnc_d = '0;
        hold_d = '0;
        if (RUN) state_d = StMonitor;
      end
      StMonitor: begin
        dbnc_d = '0;
        if (sw_rise) begin
          state_d = StRestart;
          fault_d = 2'b00;
          pls_d   = '0;
        end else if (lock_lost) begin
          // The Monitor cycle that sees the loss is the first debounce sample.
          state_d = StDebounce;
          dbnc_d  = 8'd1;
        end else if (!RUN) begin
          state_d = StIdle;
        end
      end
      StDebounce: begin
        if (!lock_lost) begin
          dbnc_d  = '0;
          state_d = StMonitor;
        end else if (dbnc_q >= DbncLast) begin
          dbnc_d  = '0;
          state_d = StRestart;
          fault_d = {~MMCM_LOCK, ~QPLL_LOCK};
          pls_d   = '0;
        end else begin
          dbnc_d = dbnc_q + 8'd1;
        end
      end
      StRestart: begin
        if (pls_q >= PlsLen) begin
          pls_d   = '0;
          state_d = StW4Drop;
        end else begin
          pulse_d = 1'b1;
          pls_d   = pls_q + 4'd1;
        end
      end
      StW4Drop: begin
        if (!RUN) state_d = StW4Run;
      end
      StW4Run: begin
        if (RUN) begin
          hold_d  = '0;
          state_d = StHoldoff;
        end
      end
      StHoldoff: begin
        if (!RUN) begin
          hold_d  = '0;
          state_d = StIdle;
        end else if ({1'b0, hold_q} + 21'd1 >= HoldLim) begin
          hold_d  = '0;
          state_d = StMonitor;
        end else begin
          hold_d = hold_q + 20'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      dbnc_q  <= '0;
      pls_q   <= '0;
      hold_q  <= '0;
      fault_q <= 2'b00;
      pulse_q <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dbnc_q  <= dbnc_d;
      pls_q   <= pls_d;
      hold_q  <= hold_d;
      fault_q <= fault_d;
      pulse_q <= pulse_d;
      sw_q    <= SW_RESTART;
    end
  end

`ifdef RESTART_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (state_d == StRestart && state_q != StRestart && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign RESTART_CNT = cnt_q;
`endif

  assign RESTART_ALL = pulse_q;
  assign FAULT_SRC   = fault_q;
  assign RCTL_STATE  = state_q;

endmodule

// File: tb/tb_lock_restart_ctrl.sv
// Self-checking bench for lock_restart_ctrl: restart pulses are scoreboarded
// against expected start cycle, width and fault source.
module tb_lock_restart_ctrl;

  logic       CLK = 1'b0;
  logic       RST, RUN, QPLL_LOCK, MMCM_LOCK, SW_RESTART;
  logic       RESTART_ALL;
  logic [1:0] FAULT_SRC;
  logic [2:0] RCTL_STATE;
`ifdef RESTART_CNT_EN
  logic [7:0] RESTART_CNT;
`endif

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] width;
    logic [1:0]  fs;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;

  lock_restart_ctrl #(
    .DBNC_LEN(16),
    .PLS_LEN (4),
    .HOLDOFF (100)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RUN        (RUN),
    .QPLL_LOCK  (QPLL_LOCK),
    .MMCM_LOCK  (MMCM_LOCK),
    .SW_RESTART (SW_RESTART),
    .RESTART_ALL(RESTART_ALL),
    .FAULT_SRC  (FAULT_SRC),
    .RCTL_STATE (RCTL_STATE)
`ifdef RESTART_CNT_EN
    ,
    .RESTART_CNT(RESTART_CNT)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: records start edge number, width and FAULT_SRC of each pulse.
  logic   in_pulse = 1'b0;
  pulse_t cur;
  always @(negedge CLK) begin
    if (RESTART_ALL === 1'b1) begin
      if (!in_pulse) begin
        in_pulse  = 1'b1;
        cur.start = cyc;
        cur.width = 0;
        cur.fs    = FAULT_SRC;
      end
      cur.width = cur.width + 1;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      obs_q.push_back(cur);
    end
  end

  // Leaves W4Drop, passes W4Run, then spends the full holdoff (100 cycles).
  task automatic recover();
    RUN = 1'b0;
    @(negedge CLK);
    RUN = 1'b1;
    repeat (101) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; RUN = 1'b0; QPLL_LOCK = 1'b1; MMCM_LOCK = 1'b1; SW_RESTART = 1'b0;
    repeat (3) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", RCTL_STATE);
    end
    n_tests++;
    if (RESTART_ALL !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse: got %b want 0", RESTART_ALL);
    end
    n_tests++;
    if (FAULT_SRC !== 2'b00) begin
      n_fail++; $display("FAIL reset_fault: got %b want 00", FAULT_SRC);
    end
`ifdef RESTART_CNT_EN
    n_tests++;
    if (RESTART_CNT !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", RESTART_CNT);
    end
`endif
    RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd0) begin
      n_fail++; $display("FAIL idle_hold: got %0d want 0", RCTL_STATE);
    end
    RUN = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd1) begin
      n_fail++; $display("FAIL idle_to_monitor: got %0d want 1", RCTL_STATE);
    end
  endtask

  task automatic test_lock_loss();
    pulse_t e, o;
    int t0 = cyc;
    exp_q.push_back('{start: t0 + 17, width: 4, fs: 2'b01});
    QPLL_LOCK = 1'b0;
    repeat (16) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd3 || RESTART_ALL !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_enter_restart: state %0d pulse %b want 3 0", RCTL_STATE, RESTART_ALL);
    end
    QPLL_LOCK = 1'b1;
    repeat (5) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd4 || RESTART_ALL !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_w4drop: state %0d pulse %b want 4 0", RCTL_STATE, RESTART_ALL);
    end
`ifdef RESTART_CNT_EN
    n_tests++;
    if (RESTART_CNT !== 8'd1) begin
      n_fail++; $display("FAIL lock_cnt: got %0d want 1", RESTART_CNT);
    end
`endif
    RUN = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd5) begin
      n_fail++; $display("FAIL lock_w4run: got %0d want 5", RCTL_STATE);
    end
    RUN = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd6) begin
      n_fail++; $display("FAIL lock_holdoff: got %0d want 6", RCTL_STATE);
    end
    repeat (100) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd1 || FAULT_SRC !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_recovered: state %0d fault %b want 1 01", RCTL_STATE, FAULT_SRC);
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL lock_npulse: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL lock_pulse: got start %0d width %0d fs %b want start %0d width %0d fs %b",
                 o.start, o.width, o.fs, e.start, e.width, e.fs);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    MMCM_LOCK = 1'b0;
    repeat (15) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd2) begin
      n_fail++; $display("FAIL glitch_debounce: got %0d want 2", RCTL_STATE);
    end
    MMCM_LOCK = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd1) begin
      n_fail++; $display("FAIL glitch_monitor: got %0d want 1", RCTL_STATE);
    end
    repeat (10) @(negedge CLK);
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL glitch_npulse: got %0d want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_sw_restart();
    pulse_t e, o;
    int t0 = cyc;
    exp_q.push_back('{start: t0 + 2, width: 4, fs: 2'b00});
    SW_RESTART = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd3) begin
      n_fail++; $display("FAIL sw_restart_state: got %0d want 3", RCTL_STATE);
    end
    repeat (5) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd4 || FAULT_SRC !== 2'b00) begin
      n_fail++;
      $display("FAIL sw_w4drop: state %0d fault %b want 4 00", RCTL_STATE, FAULT_SRC);
    end
    // Request stays high through recovery and into Monitor: must not retrigger.
    recover();
    repeat (10) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd1) begin
      n_fail++; $display("FAIL sw_no_retrigger: got %0d want 1", RCTL_STATE);
    end
    SW_RESTART = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sw_npulse: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sw_pulse: got start %0d width %0d fs %b want start %0d width %0d fs %b",
                 o.start, o.width, o.fs, e.start, e.width, e.fs);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_holdoff();
    pulse_t e, o;
    int t0 = cyc;
    int h;
    exp_q.push_back('{start: t0 + 2, width: 4, fs: 2'b00});
    SW_RESTART = 1'b1;
    @(negedge CLK);
    SW_RESTART = 1'b0;
    repeat (5) @(negedge CLK);
    RUN = 1'b0;
    @(negedge CLK);
    RUN = 1'b1;
    @(negedge CLK);
    h = cyc;
    QPLL_LOCK = 1'b0; MMCM_LOCK = 1'b0;
    repeat (50) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd6 || RESTART_ALL !== 1'b0) begin
      n_fail++;
      $display("FAIL holdoff_ignore: state %0d pulse %b want 6 0", RCTL_STATE, RESTART_ALL);
    end
    QPLL_LOCK = 1'b1; MMCM_LOCK = 1'b1;
    repeat (10) @(negedge CLK);
    QPLL_LOCK = 1'b0; MMCM_LOCK = 1'b0;
    exp_q.push_back('{start: h + 117, width: 4, fs: 2'b11});
    repeat (39) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd6) begin
      n_fail++; $display("FAIL holdoff_last: got %0d want 6", RCTL_STATE);
    end
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd1) begin
      n_fail++; $display("FAIL holdoff_end: got %0d want 1", RCTL_STATE);
    end
    repeat (16) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd3) begin
      n_fail++; $display("FAIL holdoff_fault_restart: got %0d want 3", RCTL_STATE);
    end
    repeat (5) @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd4 || FAULT_SRC !== 2'b11) begin
      n_fail++;
      $display("FAIL holdoff_fault_src: state %0d fault %b want 4 11", RCTL_STATE, FAULT_SRC);
    end
    QPLL_LOCK = 1'b1; MMCM_LOCK = 1'b1;
    recover();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL holdoff_npulse: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL holdoff_pulse: got start %0d width %0d fs %b want start %0d width %0d fs %b",
                 o.start, o.width, o.fs, e.start, e.width, e.fs);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_pulse();
    pulse_t e, o;
    int t0 = cyc;
    exp_q.push_back('{start: t0 + 17, width: 2, fs: 2'b01});
    QPLL_LOCK = 1'b0;
    repeat (18) @(negedge CLK);
    n_tests++;
    if (RESTART_ALL !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pulse_high: got %b want 1", RESTART_ALL);
    end
    RST = 1'b1; QPLL_LOCK = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (RESTART_ALL !== 1'b0 || RCTL_STATE !== 3'd0 || FAULT_SRC !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_clear: pulse %b state %0d fault %b want 0 0 00",
               RESTART_ALL, RCTL_STATE, FAULT_SRC);
    end
    RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (RCTL_STATE !== 3'd1) begin
      n_fail++; $display("FAIL midrst_resume: got %0d want 1", RCTL_STATE);
    end
    repeat (3) @(negedge CLK);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midrst_npulse: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midrst_pulse: got start %0d width %0d fs %b want start %0d width %0d fs %b",
                 o.start, o.width, o.fs, e.start, e.width, e.fs);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef RESTART_CNT_EN
  task automatic test_restart_cnt();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (RESTART_CNT !== 8'd0 || RCTL_STATE !== 3'd1) begin
      n_fail++;
      $display("FAIL cnt_start: cnt %0d state %0d want 0 1", RESTART_CNT, RCTL_STATE);
    end
    for (int i = 1; i <= 257; i++) begin
      SW_RESTART = 1'b1;
      @(negedge CLK);
      SW_RESTART = 1'b0;
      repeat (5) @(negedge CLK);
      recover();
      if (i == 1 || i == 256 || i == 257) begin
        n_tests++;
        if (RESTART_CNT !== ((i > 255) ? 8'hFF : 8'(i))) begin
          n_fail++; $display("FAIL cnt_after_%0d: got %0d", i, RESTART_CNT);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_lock_loss();
    test_glitch();
    test_sw_restart();
    test_holdoff();
    test_reset_mid_pulse();
`ifdef RESTART_CNT_EN
    test_restart_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_restart_ctrl.md
LOCK_RESTART_CTRL -- requirements
Module: lock_restart_ctrl

Interface
REQ-001 Parameter DBNC_LEN, default 16: consecutive cycles a lock loss must persist before it counts as a fault (range 1..255).
REQ-002 Parameter PLS_LEN, default 4: width in cycles of the RESTART_ALL pulse (range 1..15).
REQ-003 Parameter HOLDOFF, default 20'hFFFFF: cycles after a completed restart during which new faults are ignored.
REQ-004 Port: CLK  input  1  sole clock; all logic is on its rising edge.
REQ-005 Port: RST  input  1  synchronous, active-high reset.
REQ-006 Port: RUN  input  1  high while the power-on-reset sequencer is in its run state.
REQ-007 Port: QPLL_LOCK  input  1  QPLL lock status.
REQ-008 Port: MMCM_LOCK  input  1  system MMCM lock status.
REQ-009 Port: SW_RESTART  input  1  software restart request; only its rising edge is used.
REQ-010 Port: RESTART_ALL  output  1  registered restart pulse to the sequencer.
REQ-011 Port: FAULT_SRC  output  2  latched cause of the last restart: bit0 QPLL, bit1 MMCM; 2'b00 means software.
REQ-012 Port: RCTL_STATE  output  3  current state encoding.
REQ-013 Port: RESTART_CNT  output  8  number of restarts issued (present only with RESTART_CNT_EN).

Function
REQ-014 States and encodings: Idle=0, Monitor=1, Debounce=2, Restart=3, W4Drop=4, W4Run=5, Holdoff=6; RCTL_STATE shall equal the current state.
REQ-015 Idle: go to Monitor when RUN=1; otherwise stay.
REQ-016 Monitor, in priority order: SW_RESTART rising edge -> Restart with FAULT_SRC=00; else any lock low -> Debounce; else RUN=0 -> Idle.
REQ-017 Debounce: the counter increments while any lock is low and clears when both locks are high; a clear returns the FSM to Monitor.
REQ-018 Debounce exit: when the counter reaches DBNC_LEN-1 with a lock still low, go to Restart and latch FAULT_SRC={~MMCM_LOCK,~QPLL_LOCK} from that cycle.
REQ-019 Restart: RESTART_ALL=1 for exactly PLS_LEN consecutive cycles, then go to W4Drop.
REQ-020 RESTART_ALL shall be registered, is asserted only in Restart, and has its first high cycle on the cycle after Restart is entered.
REQ-021 W4Drop: go to W4Run when RUN=0.
REQ-022 W4Run: go to Holdoff when RUN=1.
REQ-023 Holdoff: lock losses and SW_RESTART are ignored for HOLDOFF cycles (20-bit counter), then go to Monitor.
REQ-024 Holdoff with RUN=0: if RUN falls during Holdoff, go to Idle and clear the holdoff counter.
REQ-025 FAULT_SRC holds its value until the next entry to Restart.
REQ-026 Edge detection: SW_RESTART is registered once to detect the edge; a request held high does not retrigger.
REQ-027 Inputs: all inputs are synchronous to CLK.
REQ-028 Unused encodings (7) shall go to Idle on the next cycle.

Reset
REQ-029 While RST=1 on a clock edge: state=Idle, RESTART_ALL=0, FAULT_SRC=00, all counters and the SW_RESTART edge register cleared, RESTART_CNT=0.
REQ-030 Reset mid-pulse: RST asserted during Restart shall terminate RESTART_ALL on the same edge.

Configuration
REQ-031 Macro RESTART_CNT_EN defined: RESTART_CNT increments on each entry to Restart and saturates at 8'hFF.
REQ-032 Macro RESTART_CNT_EN undefined: the RESTART_CNT port and its counter are absent, and all other behaviour is unchanged.

Verification
REQ-033 Lock loss: RUN=1, drop QPLL_LOCK for 16 cycles -> RESTART_ALL high 4 cycles starting cycle 17, FAULT_SRC=01.
REQ-034 Glitch filtering: drop MMCM_LOCK for 15 cycles then restore -> no RESTART_ALL, state returns to Monitor.
REQ-035 Software restart: SW_RESTART held high 100 cycles -> exactly one 4-cycle RESTART_ALL pulse, FAULT_SRC=00.
REQ-036 Holdoff suppression: with HOLDOFF=100, after RUN recovers drop both locks 50 cycles -> no restart; fault persisting past cycle 100 plus 16 -> restart with FAULT_SRC=11.
REQ-037 Reset during pulse: RST in the 2nd cycle of RESTART_ALL -> output low next edge, state Idle, FAULT_SRC=00.
REQ-038 Counter saturation (RESTART_CNT_EN): 256 software restarts -> RESTART_CNT reads 8'hFF.
